// File: rtl/definitions.sv
// Shared types and default widths for the core launch sequencer.
package definitions;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } launcher_state_t;

  localparam int unsigned DefReqCycles     = 2;
  localparam int unsigned DefCntBits       = 16;
  localparam int unsigned DefTimeoutCycles = 4096;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/core_launcher.sv
// Host-side req/ack run sequencer for the processor core.
// Optional watchdog enabled by defining CORE_LAUNCHER_TIMEOUT_EN.
module core_launcher
  import definitions::*;
#(
  parameter int unsigned REQ_CYCLES     = DefReqCycles,
  parameter int unsigned CNT_BITS       = DefCntBits,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                host_start,
  output logic                host_busy,
  output logic                host_done,
  output logic                host_timeout,
  output logic [CNT_BITS-1:0] cycles,
  output logic                core_req,
  input  logic                core_ack
);

  localparam int unsigned HoldW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(REQ_CYCLES - 1);

  launcher_state_t     state_q;
  logic [HoldW-1:0]    hold_q;
  logic                ack_q;
  logic                req_q, busy_q, done_q, timeout_q;
  logic [CNT_BITS-1:0] cycles_q;
  logic [CNT_BITS-1:0] cnt;
  logic                cnt_clear, cnt_enable;

  // Raw ack is combinational from the core; only the registered copy steers the FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) ack_q <= 1'b0;
    else          ack_q <= core_ack;
  end

  assign cnt_clear  = (state_q == START) && (hold_q == '0);
  assign cnt_enable = (state_q == RUN) && !ack_q;

  sat_counter #(
    .Width(CNT_BITS)
  ) u_cycle_cnt (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clear_i (cnt_clear),
    .enable_i(cnt_enable),
    .count_o (cnt)
  );

`ifdef CORE_LAUNCHER_TIMEOUT_EN
  localparam logic [CNT_BITS-1:0] TimeoutLast = CNT_BITS'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (host_start) begin
            state_q   <= START;
            hold_q    <= HoldLoad;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (hold_q == '0) begin
            state_q <= RUN;
            req_q   <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        RUN: begin
          if (ack_q) begin
            state_q  <= DONE;
            cycles_q <= cnt;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end
`ifdef CORE_LAUNCHER_TIMEOUT_EN
          else if (cnt == TimeoutLast) begin
            state_q   <= DONE;
            cycles_q  <= cnt;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_req  = req_q;
  assign host_busy = busy_q;
  assign host_done = done_q;
  assign cycles    = cycles_q;
`ifdef CORE_LAUNCHER_TIMEOUT_EN
  assign host_timeout = timeout_q;
`else
  assign host_timeout = 1'b0;
  logic unused_timeout_q;
  assign unused_timeout_q = timeout_q;
`endif

endmodule

// File: doc/core_launcher.md
# core_launcher

Host-side sequencer that sits directly upstream of the processor top level and drives its `req`/`ack` run handshake. On a one-cycle host start pulse it resets the core by holding `core_req` high for a fixed number of cycles, then releases it and waits for the core's level `ack`. It counts execution cycles and reports completion, with an optional watchdog timeout, to the host.

## Interface
- `REQ_CYCLES`, default 2: cycles `core_req` is held high per launch; legal range ≥1.
- `CNT_BITS`, default 16: width of the cycle counter and the `cycles` output.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in RUN cycles; ≤ 2^CNT_BITS − 1; used only with the timeout feature.
- `clock` in, 1: single clock; all state updates on the rising edge.
- `reset_n` in, 1: synchronous, active-low reset.
- `host_start` in, 1: launch request; sampled only in IDLE.
- `host_busy` out, 1: high in START and RUN.
- `host_done` out, 1: one-cycle completion pulse.
- `host_timeout` out, 1: the last run ended by watchdog; held until the next accepted `host_start`.
- `cycles` out, CNT_BITS: cycle count of the last run; held until the next accepted `host_start`.
- `core_req` out, 1: drives the core's `req`/start.
- `core_ack` in, 1: the core's combinational `ack` (PC at done address).

## Operation
- `core_ack` is registered once (`ack_q`). The FSM uses only `ack_q`, never the raw input.
- States: IDLE, START, RUN, DONE.
- **IDLE:** `host_start`=1 moves to START. On that transition, `cycles` clears to 0, `host_timeout` clears to 0, and the hold counter loads REQ_CYCLES−1.
- **START:** `core_req`=1. The hold counter decrements; at 0 it moves to RUN and the cycle counter clears. `ack_q` is ignored here.
- **RUN:** `core_req`=0.
  - `ack_q`=0: the cycle counter increments and saturates at all-ones.
  - `ack_q`=1: move to DONE and latch `cycles` ← counter.
- **DONE:** `host_done`=1 for exactly this cycle, then move to IDLE.
- `host_start` outside IDLE is ignored. Launches are not queued.
- `host_start` in the same cycle as the DONE→IDLE edge is ignored. It is accepted from IDLE onward.
- `ack_q` already high at RUN entry (e.g. a stale ack) ends the run immediately with `cycles`=0.
- Reset at any point, including mid-RUN, returns to IDLE with all outputs at their reset values. `core_req` drops in the cycle after the reset edge.

## Timing
- Reset values: `core_req`=0, `host_busy`=0, `host_done`=0, `host_timeout`=0, `cycles`=0, state IDLE.
- The `host_start`-sampled edge is E0. `core_req` is high in cycles E0..E0+REQ_CYCLES−1 and low from E0+REQ_CYCLES.
- If raw `ack` first rises after k RUN edges, then `ack_q` is seen one edge later, `cycles` = k+1, and `host_done` pulses in the following cycle.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `CORE_LAUNCHER_TIMEOUT_EN` defined:
  - In RUN, if the counter equals TIMEOUT_CYCLES−1 and `ack_q`=0, move to DONE with `cycles`=TIMEOUT_CYCLES−1 and `host_timeout`=1.
  - If `ack_q`=1 on that same cycle, ack wins and `host_timeout`=0.
- Undefined: no watchdog. `host_timeout` is tied to 0, TIMEOUT_CYCLES is unused, and RUN waits indefinitely with the counter saturating.

## Structure
- The `definitions` package holds the `launcher_state_t` enum (IDLE, START, RUN, DONE) and the default widths.
- One sub-module, `sat_counter`: parameterised width, with clear, enable, and saturate-at-max. It is instantiated for the cycle counter.
- The hold counter and FSM are inline.

## Test plan
- Launch: REQ_CYCLES=2, raw ack rises after 3 RUN edges → `core_req` high for exactly 2 cycles, `cycles`=4, one-cycle `host_done`, `host_busy` low afterward.
- `host_start` pulsed in START and in RUN → ignored. Exactly one `host_done`, and `cycles` is unchanged by the extra pulses.
- Ack held high through START → not acted on. The run ends on the first RUN cycle with `cycles`=0.
- `reset_n`=0 mid-RUN → next cycle all outputs 0, state IDLE. A later launch behaves normally.
- With `CORE_LAUNCHER_TIMEOUT_EN` and TIMEOUT_CYCLES=8, ack never rising → `host_done` with `host_timeout`=1 and `cycles`=7. The next `host_start` clears `host_timeout`.
- Without the macro, CNT_BITS=4 and ack withheld for 20 RUN cycles → counter saturates at 15 and no `host_done`. Ack then rises → `cycles`=15, `host_timeout`=0.
